// File: rtl/pc_gen.sv
// Fetch sequencer: drives the fetch PC toward the I-cache path, queues responses toward
// decode, and applies branch/trap redirects while keeping pc stable until the response arrives.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        inst_r_ready,
  input  logic [31:0] inst,
  input  logic        inst_r_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  // Registered state
  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_pend_pc;
  logic             r_inst_r_ready;
  logic             r_id_valid;
  fq_entry_t        r_head;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fq_entry_t        r_fq [FQ_DEPTH];

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [XLEN-1:0]  w_pend_nxt;
  logic             w_ready_nxt;
  fq_entry_t        w_head_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  logic             w_redirect;
  logic [XLEN-1:0]  w_target_raw;
  logic [XLEN-1:0]  w_target;
  logic             w_handshake;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Redirect target selection: trap wins, low bits forced to word alignment
  always_comb begin
    w_redirect   = trap_valid | redirect_valid;
    w_target_raw = trap_valid ? trap_pc : redirect_pc;
    w_target     = {w_target_raw[XLEN-1:2], 2'b00};
    w_handshake  = inst_r_valid & r_inst_r_ready;
    w_pop        = r_id_valid & id_ready;
  end

  // Fetch FSM: next state, next pc, pending redirect target, queue push
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;
    w_push      = 1'b0;
    w_flush     = w_redirect;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end
      end
      S_FETCH: begin
        if (w_redirect) begin
          // A response arriving with the redirect is stale but closes the fetch
          if (w_handshake) begin
            w_pc_nxt = w_target;
          end else begin
            w_pend_nxt  = w_target;
            w_state_nxt = S_DRAIN;
          end
        end else if (w_handshake) begin
          w_push   = 1'b1;
          w_pc_nxt = XLEN'(r_pc + PC_STEP);
        end
      end
      S_DRAIN: begin
        if (w_handshake) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = w_redirect ? w_target : r_pend_pc;
        end else if (w_redirect) begin
          w_pend_nxt = w_target;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // Fetch queue bookkeeping and next head entry
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (w_flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_pop) begin
        w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
      end
      if (w_push) begin
        w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = CNT_W'(r_count + CNT_W'(1));
        2'b01:   w_count_nxt = CNT_W'(r_count - CNT_W'(1));
        default: w_count_nxt = r_count;
      endcase
    end

    // The entry being written this cycle becomes the head when it lands at the read slot
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = '{pc: r_pc, inst: inst};
    end else begin
      w_head_nxt = r_fq[w_rd_ptr_nxt];
    end

    case (w_state_nxt)
      S_FETCH: w_ready_nxt = (w_count_nxt < CNT_FULL);
      S_DRAIN: w_ready_nxt = 1'b1;
      default: w_ready_nxt = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_PC;
      r_pend_pc      <= '0;
      r_inst_r_ready <= 1'b0;
      r_id_valid     <= 1'b0;
      r_head         <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_pend_pc      <= w_pend_nxt;
      r_inst_r_ready <= w_ready_nxt;
      r_id_valid     <= (w_count_nxt != '0);
      r_head         <= w_head_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_count        <= w_count_nxt;
    end
  end

  // Queue storage; contents are only meaningful under r_count, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fq[r_wr_ptr] <= '{pc: r_pc, inst: inst};
    end
  end

  assign pc           = r_pc;
  assign inst_r_ready = r_inst_r_ready;
  assign id_valid     = r_id_valid;
  assign id_pc        = r_head.pc;
  assign id_inst      = r_head.inst;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: table of per-cycle vectors with a scoreboard of expected IDU entries,
// plus a second instance exercising PC wrap-around from a high reset PC.
module tb_pc_gen;

  typedef struct {
    bit          rst_n;
    bit          iv;
    logic [31:0] inst;
    bit          rv;
    logic [31:0] rpc;
    bit          tv;
    logic [31:0] tpc;
    bit          idr;
    bit          push;
    logic [31:0] e_pc;
    bit          e_rdy;
    bit          e_idv;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        inst_r_ready;
  logic [31:0] inst;
  logic        inst_r_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic        rst2;
  logic [31:0] pc2;
  logic        rdy2;
  logic [31:0] inst2;
  logic        iv2;
  logic        zero_bit;
  logic [31:0] zero_word;
  logic        idv2;
  logic        idr2;
  logic [31:0] idpc2;
  logic [31:0] idinst2;

  int n_cmp;
  int n_mis;

  vec_t vecs[$];
  ent_t sb[$];

  pc_gen #(.RESET_PC(32'h8000_0000), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_r_ready(inst_r_ready), .inst(inst),
    .inst_r_valid(inst_r_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst)
  );

  pc_gen #(.RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst2), .pc(pc2), .inst_r_ready(rdy2), .inst(inst2),
    .inst_r_valid(iv2), .redirect_valid(zero_bit), .redirect_pc(zero_word),
    .trap_valid(zero_bit), .trap_pc(zero_word), .id_valid(idv2), .id_ready(idr2),
    .id_pc(idpc2), .id_inst(idinst2)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(bit rst_n, bit iv, logic [31:0] ins, bit rv, logic [31:0] rpc,
                             bit tv, logic [31:0] tpc, bit idr, bit push,
                             logic [31:0] e_pc, bit e_rdy, bit e_idv);
    vec_t r;
    r.rst_n = rst_n; r.iv = iv; r.inst = ins; r.rv = rv; r.rpc = rpc; r.tv = tv;
    r.tpc = tpc; r.idr = idr; r.push = push; r.e_pc = e_pc; r.e_rdy = e_rdy; r.e_idv = e_idv;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          prev_idv;
    logic [31:0] prev_pc;
    ent_t        e;
    int          waited;

    clk = 1'b0; rst = 1'b0; rst2 = 1'b0;
    inst = '0; inst_r_valid = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0; id_ready = 1'b0;
    inst2 = '0; iv2 = 1'b0; idr2 = 1'b0; zero_bit = 1'b0; zero_word = '0;
    n_cmp = 0; n_mis = 0;
    prev_idv = 1'b0; prev_pc = '0;

    // reset and boot
    repeat (3) vecs.push_back(v(0,0,32'h0,0,32'h0,0,32'h0,0,0,32'h8000_0000,0,0));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,0,0,32'h8000_0000,1,0));
    // streaming
    vecs.push_back(v(1,1,32'h13,0,32'h0,0,32'h0,1,1,32'h8000_0004,1,1));
    vecs.push_back(v(1,1,32'h13,0,32'h0,0,32'h0,1,1,32'h8000_0008,1,1));
    vecs.push_back(v(1,1,32'h13,0,32'h0,0,32'h0,1,1,32'h8000_000C,1,1));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,1,0,32'h8000_000C,1,0));
    // backpressure
    vecs.push_back(v(1,1,32'h1,0,32'h0,0,32'h0,0,1,32'h8000_0010,1,1));
    vecs.push_back(v(1,1,32'h2,0,32'h0,0,32'h0,0,1,32'h8000_0014,0,1));
    vecs.push_back(v(1,1,32'h3,0,32'h0,0,32'h0,0,0,32'h8000_0014,0,1));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,1,0,32'h8000_0014,1,1));
    vecs.push_back(v(1,1,32'h4,0,32'h0,0,32'h0,1,1,32'h8000_0018,1,1));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,1,0,32'h8000_0018,1,0));
    // stale drop through DRAIN
    vecs.push_back(v(1,0,32'h0,1,32'h8000_1000,0,32'h0,0,0,32'h8000_0018,1,0));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,0,0,32'h8000_0018,1,0));
    vecs.push_back(v(1,1,32'hDEAD_BEEF,0,32'h0,0,32'h0,0,0,32'h8000_1000,1,0));
    vecs.push_back(v(1,1,32'h100,0,32'h0,0,32'h0,1,1,32'h8000_1004,1,1));
    // redirect with accept and pop in the same cycle
    vecs.push_back(v(1,1,32'h200,1,32'h8000_3000,0,32'h0,1,0,32'h8000_3000,1,0));
    // trap priority, then misaligned redirect with same-cycle accept
    vecs.push_back(v(1,0,32'h0,1,32'h8000_2000,1,32'h8000_0100,0,0,32'h8000_3000,1,0));
    vecs.push_back(v(1,1,32'hBAD,0,32'h0,0,32'h0,0,0,32'h8000_0100,1,0));
    vecs.push_back(v(1,1,32'h500,1,32'h8000_1002,0,32'h0,0,0,32'h8000_1000,1,0));
    // latest redirect in DRAIN wins; redirect on the drain handshake
    vecs.push_back(v(1,0,32'h0,1,32'h8000_4000,0,32'h0,0,0,32'h8000_1000,1,0));
    vecs.push_back(v(1,0,32'h0,0,32'h0,1,32'h8000_5003,0,0,32'h8000_1000,1,0));
    vecs.push_back(v(1,1,32'h600,0,32'h0,0,32'h0,0,0,32'h8000_5000,1,0));
    vecs.push_back(v(1,0,32'h0,1,32'h8000_6000,0,32'h0,0,0,32'h8000_5000,1,0));
    vecs.push_back(v(1,1,32'h700,1,32'h8000_7000,0,32'h0,0,0,32'h8000_7000,1,0));
    vecs.push_back(v(1,1,32'h300,0,32'h0,0,32'h0,0,1,32'h8000_7004,1,1));
    // reset while in DRAIN, reset beating a redirect, redirect during BOOT
    vecs.push_back(v(1,0,32'h0,1,32'h8000_8000,0,32'h0,0,0,32'h8000_7004,1,0));
    vecs.push_back(v(0,0,32'h0,0,32'h0,0,32'h0,0,0,32'h8000_0000,0,0));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,0,0,32'h8000_0000,1,0));
    vecs.push_back(v(0,1,32'h800,1,32'h8000_A000,0,32'h0,0,0,32'h8000_0000,0,0));
    vecs.push_back(v(1,0,32'h0,1,32'h8000_9000,0,32'h0,0,0,32'h8000_9000,1,0));
    vecs.push_back(v(1,1,32'h400,0,32'h0,0,32'h0,1,1,32'h8000_9004,1,1));
    vecs.push_back(v(1,0,32'h0,0,32'h0,0,32'h0,1,0,32'h8000_9004,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_n; inst_r_valid = vecs[i].iv; inst = vecs[i].inst;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      trap_valid = vecs[i].tv; trap_pc = vecs[i].tpc; id_ready = vecs[i].idr;

      if (!vecs[i].rst_n) begin
        sb.delete();
      end else begin
        if (prev_idv && vecs[i].idr && sb.size() != 0) void'(sb.pop_front());
        if (vecs[i].rv || vecs[i].tv) sb.delete();
        if (vecs[i].push) sb.push_back('{pc: prev_pc, inst: vecs[i].inst});
      end

      tick();
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d inst_r_ready", i), 32'(inst_r_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_idv));
      if (!vecs[i].rst_n) begin
        chk($sformatf("v%0d reset id_pc", i), id_pc, 32'h0);
        chk($sformatf("v%0d reset id_inst", i), id_inst, 32'h0);
      end else if (vecs[i].e_idv) begin
        if (sb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL v%0d scoreboard: got empty queue, required an expected entry", i);
        end else begin
          e = sb[0];
          chk($sformatf("v%0d id_pc", i), id_pc, e.pc);
          chk($sformatf("v%0d id_inst", i), id_inst, e.inst);
        end
      end
      prev_idv = vecs[i].e_idv;
      prev_pc  = vecs[i].e_pc;
    end

    // PC wrap from a reset PC at the top of the address space
    chk("wrap reset pc", pc2, 32'hFFFF_FFFC);
    chk("wrap boot ready", 32'(rdy2), 32'h0);
    rst2 = 1'b1;
    tick();
    chk("wrap fetch ready", 32'(rdy2), 32'h1);
    iv2 = 1'b1; inst2 = 32'h13; idr2 = 1'b1;
    tick();
    chk("wrap second pc", pc2, 32'h0000_0000);
    waited = 0;
    while (!idv2 && waited < 4) begin
      tick();
      waited++;
    end
    chk("wrap id_valid latency", 32'(waited), 32'h0);
    chk("wrap id_pc 0", idpc2, 32'hFFFF_FFFC);
    tick();
    chk("wrap third pc", pc2, 32'h0000_0004);
    chk("wrap id_pc 1", idpc2, 32'h0000_0000);
    chk("wrap id_inst", idinst2, 32'h13);
    iv2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
